hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core (IF, DEC, EX, MEM, WB). It keeps a shadow scoreboard of destination registers in EX/MEM/WB and drives operand-forwarding selects. It also generates load-use stalls, kills IF/DEC on taken branches, and freezes the whole pipeline while a data-memory access waits for `mem_ready`. The IR_kill/Dec_kill requests from decode control terminate here.

## Interface
- `XLEN_CNT`, 32, width of the stall-cycle performance counter
- `clk`  in  1  core clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `dec_valid`  in  1  DEC holds a live instruction
- `dec_rs1`, `dec_rs2`  in  5  source registers of the DEC instruction
- `dec_use_rs1`, `dec_use_rs2`  in  1  the DEC instruction actually reads that source
- `dec_rd`  in  5  destination of the DEC instruction
- `dec_reg_wen`  in  1  the DEC instruction writes `dec_rd`
- `dec_is_load`  in  1  the DEC instruction is a load
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump this cycle
- `mem_req`  in  1  MEM stage is issuing a data-memory access
- `mem_ready`  in  1  data memory completes the access this cycle
- `pc_stall`  out  1  hold PC
- `ir_stall`  out  1  hold IF/DEC register
- `ex_stall`  out  1  hold DEC/EX and later pipeline registers (freeze only)
- `ex_bubble`  out  1  load NOP into DEC/EX
- `ir_kill`  out  1  squash the IF/DEC register contents
- `dec_kill`  out  1  squash the DEC instruction (becomes bubble)
- `fwd_a_sel`, `fwd_b_sel`  out  2  rs1/rs2 source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
- `stall_cycles`  out  XLEN_CNT  count of cycles with `pc_stall`=1

## Operation
- The shadow scoreboard has three entries, EX, MEM and WB. Each entry holds {valid, rd, wen, is_load}.
- The shadow advances when `ex_stall`=0: WB←MEM, MEM←EX, EX←DEC fields.
- When `ex_bubble`=1 or `dec_kill`=1, EX is loaded with valid=0.
- A hit occurs when the entry is valid, its wen=1, its rd≠0, and its rd equals the used rs.
- Forwarding for each source uses priority EX > MEM > WB > regfile.
- x0 and unused sources always select 0.
- The load-use condition is: `dec_valid` and an EX-entry hit, where that EX entry has is_load=1.
  - It drives `pc_stall`=`ir_stall`=`ex_bubble`=1 for one cycle.
  - After one cycle the load sits in MEM and forwarding selects 2.
- Taken branch: `ex_branch_taken`=1 while not frozen drives `ir_kill`=`dec_kill`=1 in the same cycle.
  - It overrides load-use: no stall is issued and no stall is counted.
- Memory freeze FSM has two states, RUN and WAIT.
  - RUN→WAIT when `mem_req`=1 and `mem_ready`=0.
  - WAIT→RUN when `mem_ready`=1.
  - `mem_req`=1 with `mem_ready`=1 in RUN does not freeze.
  - While in WAIT, or on the RUN cycle that transitions to WAIT:
    - `pc_stall`=`ir_stall`=`ex_stall`=1.
    - `ex_bubble`, `ir_kill` and `dec_kill` are 0.
    - The shadow holds.
  - `ex_branch_taken` is held by the datapath during a freeze. The kill is issued on the first unfrozen cycle.
- `stall_cycles` increments on every cycle with `pc_stall`=1. It saturates at all-ones.

## Timing
- Reset state:
  - Shadow valid bits 0, FSM in RUN, `stall_cycles`=0.
  - All stall, kill and bubble outputs 0.
  - `fwd_a_sel`=`fwd_b_sel`=0.
- Forward selects, stalls, kills and bubble are combinational from the inputs and the shadow. Zero-cycle latency.
- The FSM, shadow and counter are registered. They update at the edge following the condition.
- A load-use stall lasts exactly 1 cycle per dependent instruction. A back-to-back load followed by its use costs 1 bubble.
- A freeze entered in the cycle `mem_ready` falls lasts until the cycle `mem_ready`=1, inclusive of that cycle's release. The pipeline advances at the end of the release cycle.
- `rst` asserted mid-freeze or mid-stall returns to the reset state at the next edge. All pending kills are dropped.

## Test plan
- EX: `add x5`; DEC: `sub` reads x5 → `fwd_a_sel`=1, no stall. After 1 cycle, a DEC reading x5 → sel 2. After 2 cycles → sel 3.
- EX: `lw x7`; DEC reads x7 in rs2 → `pc_stall`=`ir_stall`=`ex_bubble`=1 for 1 cycle. Next cycle `fwd_b_sel`=2 with no stall. `stall_cycles`=1.
- EX: `lw x0`, DEC reads x0 → no stall, sel 0.
- `ex_branch_taken`=1 together with a load-use condition → `ir_kill`=`dec_kill`=1, `pc_stall`=0. Next cycle the EX shadow entry is invalid.
- `mem_req`=1 with `mem_ready` low for 3 cycles then high → `ex_stall`=1 for 4 cycles, shadow unchanged, `stall_cycles`=4. A `ex_branch_taken` held throughout is killed only on the cycle after release.
- Assert `rst` during WAIT → next cycle all outputs 0, FSM in RUN, `stall_cycles`=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing control for the 5-stage RV32I pipeline.
// Tracks EX/MEM/WB destination registers in a shadow scoreboard, selects
// operand forwarding, raises load-use stalls, kills IF/DEC on taken branches
// and freezes the pipeline while a data-memory access is outstanding.
module hazard_ctrl #(
   parameter int XLEN_CNT = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dec_valid,
   input  logic [4:0]          dec_rs1,
   input  logic [4:0]          dec_rs2,
   input  logic                dec_use_rs1,
   input  logic                dec_use_rs2,
   input  logic [4:0]          dec_rd,
   input  logic                dec_reg_wen,
   input  logic                dec_is_load,
   input  logic                ex_branch_taken,
   input  logic                mem_req,
   input  logic                mem_ready,
   output logic                pc_stall,
   output logic                ir_stall,
   output logic                ex_stall,
   output logic                ex_bubble,
   output logic                ir_kill,
   output logic                dec_kill,
   output logic [1:0]          fwd_a_sel,
   output logic [1:0]          fwd_b_sel,
   output logic [XLEN_CNT-1:0] stall_cycles
);

   typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

   // The load flag is only ever consulted for the EX entry (load-use), so it
   // lives beside the EX entry instead of travelling down to MEM/WB.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
   } shadow_t;

   state_t  state, state_nxt;
   shadow_t sh_ex, sh_mem, sh_wb;
   logic    ex_is_load;
   logic    freeze;
   logic    load_use;

   function automatic logic hit(shadow_t e, logic [4:0] rs);
      return e.valid && e.wen && (e.rd != 5'd0) && (e.rd == rs);
   endfunction

   // Youngest producer wins; x0 and unread sources always come from the regfile.
   function automatic logic [1:0] fwd_sel(logic rd_used, logic [4:0] rs,
                                          shadow_t ex, shadow_t mem, shadow_t wb);
      if (!rd_used || rs == 5'd0) return 2'd0;
      if (hit(ex, rs))  return 2'd1;
      if (hit(mem, rs)) return 2'd2;
      if (hit(wb, rs))  return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [XLEN_CNT-1:0] sat_inc(logic [XLEN_CNT-1:0] v);
      return (&v) ? v : v + {{(XLEN_CNT-1){1'b0}}, 1'b1};
   endfunction

   assign fwd_a_sel = fwd_sel(dec_use_rs1, dec_rs1, sh_ex, sh_mem, sh_wb);
   assign fwd_b_sel = fwd_sel(dec_use_rs2, dec_rs2, sh_ex, sh_mem, sh_wb);

   assign load_use = dec_valid && ex_is_load &&
                     ((dec_use_rs1 && hit(sh_ex, dec_rs1)) ||
                      (dec_use_rs2 && hit(sh_ex, dec_rs2)));

   // Memory freeze state register.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Memory freeze next-state: enter WAIT on an unanswered request, leave on ready.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (mem_req && !mem_ready) state_nxt = WAIT;
         WAIT:    if (mem_ready)             state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Stall/kill/bubble outputs: freeze dominates, then branch kill, then load-use.
   always_comb begin
      freeze    = (state == WAIT) || (mem_req && !mem_ready);
      pc_stall  = 1'b0;
      ir_stall  = 1'b0;
      ex_stall  = 1'b0;
      ex_bubble = 1'b0;
      ir_kill   = 1'b0;
      dec_kill  = 1'b0;
      if (freeze) begin
         pc_stall = 1'b1;
         ir_stall = 1'b1;
         ex_stall = 1'b1;
      end else if (ex_branch_taken) begin
         ir_kill  = 1'b1;
         dec_kill = 1'b1;
      end else if (load_use) begin
         pc_stall  = 1'b1;
         ir_stall  = 1'b1;
         ex_bubble = 1'b1;
      end
   end

   // Shadow scoreboard shifts with the pipeline; bubbles and kills enter EX invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_ex.valid  <= 1'b0;
         sh_mem.valid <= 1'b0;
         sh_wb.valid  <= 1'b0;
      end else if (!ex_stall) begin
         sh_wb        <= sh_mem;
         sh_mem       <= sh_ex;
         sh_ex.valid  <= dec_valid && !ex_bubble && !dec_kill;
         sh_ex.rd     <= dec_rd;
         sh_ex.wen    <= dec_reg_wen;
         ex_is_load   <= dec_is_load;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk) begin
      if (rst)           stall_cycles <= '0;
      else if (pc_stall) stall_cycles <= sat_inc(stall_cycles);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic for hazard_ctrl,
// compared every cycle against a behavioural pipeline model.
module tb_hazard_ctrl;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          dec_valid;
   logic [4:0]    dec_rs1, dec_rs2, dec_rd;
   logic          dec_use_rs1, dec_use_rs2, dec_reg_wen, dec_is_load;
   logic          ex_branch_taken, mem_req, mem_ready;
   logic          pc_stall, ir_stall, ex_stall, ex_bubble, ir_kill, dec_kill;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [CW-1:0] stall_cycles;

   hazard_ctrl #(.XLEN_CNT(CW)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .dec_rd(dec_rd), .dec_reg_wen(dec_reg_wen), .dec_is_load(dec_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(pc_stall), .ir_stall(ir_stall), .ex_stall(ex_stall),
      .ex_bubble(ex_bubble), .ir_kill(ir_kill), .dec_kill(dec_kill),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       w;
      logic       ld;
   } ent_t;

   ent_t m_sh [3];
   bit   m_wait;
   int   m_cnt;
   bit   e_pc, e_ir, e_exs, e_bub, e_ik, e_dk;
   int   e_fa, e_fb;
   int   n_chk, n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit m_hit(int i, logic [4:0] rs);
      return m_sh[i].v && m_sh[i].w && m_sh[i].rd != 0 && m_sh[i].rd == rs;
   endfunction

   function automatic int m_sel(logic u, logic [4:0] rs);
      if (!u || rs == 0) return 0;
      for (int i = 0; i < 3; i++) if (m_hit(i, rs)) return i + 1;
      return 0;
   endfunction

   task automatic model_outputs();
      bit frz, lu;
      frz = m_wait || (mem_req && !mem_ready);
      lu  = dec_valid && m_sh[0].ld &&
            ((dec_use_rs1 && m_hit(0, dec_rs1)) || (dec_use_rs2 && m_hit(0, dec_rs2)));
      e_exs = frz;
      e_ik  = !frz && ex_branch_taken;
      e_dk  = e_ik;
      e_bub = !frz && !ex_branch_taken && lu;
      e_pc  = frz || e_bub;
      e_ir  = e_pc;
      e_fa  = m_sel(dec_use_rs1, dec_rs1);
      e_fb  = m_sel(dec_use_rs2, dec_rs2);
   endtask

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 3; i++) m_sh[i].v = 1'b0;
         m_wait = 1'b0;
         m_cnt  = 0;
      end else begin
         if (e_pc && m_cnt < CMAX) m_cnt++;
         if (!e_exs) begin
            m_sh[2] = m_sh[1];
            m_sh[1] = m_sh[0];
            m_sh[0] = '{v: dec_valid && !e_bub && !e_dk, rd: dec_rd,
                        w: dec_reg_wen, ld: dec_is_load};
         end
         if (m_wait) m_wait = !mem_ready;
         else        m_wait = mem_req && !mem_ready;
      end
   endtask

   task automatic settle();
      #4;
      model_outputs();
      chk("pc_stall",  32'(pc_stall),  32'(e_pc));
      chk("ir_stall",  32'(ir_stall),  32'(e_ir));
      chk("ex_stall",  32'(ex_stall),  32'(e_exs));
      chk("ex_bubble", 32'(ex_bubble), 32'(e_bub));
      chk("ir_kill",   32'(ir_kill),   32'(e_ik));
      chk("dec_kill",  32'(dec_kill),  32'(e_dk));
      chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e_fa));
      chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e_fb));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic dec(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wen, input logic ld);
      dec_valid = v; dec_rs1 = r1; dec_use_rs1 = u1; dec_rs2 = r2; dec_use_rs2 = u2;
      dec_rd = rd; dec_reg_wen = wen; dec_is_load = ld;
   endtask

   task automatic quiet();
      dec(0, 0, 0, 0, 0, 0, 0, 0);
      ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1;
      step();
      rst = 0;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      for (int i = 0; i < 3; i++) m_sh[i] = '0;
      m_wait = 0; m_cnt = 0;
      quiet();
      rst = 1;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;

      // Reset state
      settle();
      chk("rst_pc_stall", 32'(pc_stall), 0);
      chk("rst_fwd_a", 32'(fwd_a_sel), 0);
      chk("rst_cnt", 32'(stall_cycles), 0);
      advance();

      // ALU result forwarded from EX, then MEM, then WB
      do_reset();
      dec(1, 0, 0, 0, 0, 5, 1, 0); step();
      dec(1, 5, 1, 0, 0, 6, 1, 0); settle();
      chk("fw_ex_sel", 32'(fwd_a_sel), 1);
      chk("fw_ex_nostall", 32'(pc_stall), 0);
      advance();
      dec(1, 5, 1, 0, 0, 0, 0, 0); settle();
      chk("fw_mem_sel", 32'(fwd_a_sel), 2);
      advance();
      dec(1, 5, 1, 0, 0, 0, 0, 0); settle();
      chk("fw_wb_sel", 32'(fwd_a_sel), 3);
      advance();

      // Load-use on rs2: one bubble, then forward from MEM
      do_reset();
      dec(1, 0, 0, 0, 0, 7, 1, 1); step();
      dec(1, 0, 0, 7, 1, 8, 1, 0); settle();
      chk("lu_pc_stall", 32'(pc_stall), 1);
      chk("lu_ir_stall", 32'(ir_stall), 1);
      chk("lu_bubble", 32'(ex_bubble), 1);
      advance();
      settle();
      chk("lu_after_stall", 32'(pc_stall), 0);
      chk("lu_after_sel", 32'(fwd_b_sel), 2);
      chk("lu_after_cnt", 32'(stall_cycles), 1);
      advance();

      // Load to x0 never creates a dependency
      do_reset();
      dec(1, 0, 0, 0, 0, 0, 1, 1); step();
      dec(1, 0, 1, 0, 1, 0, 0, 0); settle();
      chk("x0_stall", 32'(pc_stall), 0);
      chk("x0_sel_a", 32'(fwd_a_sel), 0);
      chk("x0_sel_b", 32'(fwd_b_sel), 0);
      advance();

      // Taken branch overrides load-use and squashes the DEC instruction
      do_reset();
      dec(1, 0, 0, 0, 0, 7, 1, 1); step();
      dec(1, 7, 1, 0, 0, 9, 1, 0); ex_branch_taken = 1; settle();
      chk("br_ir_kill", 32'(ir_kill), 1);
      chk("br_dec_kill", 32'(dec_kill), 1);
      chk("br_pc_stall", 32'(pc_stall), 0);
      chk("br_bubble", 32'(ex_bubble), 0);
      advance();
      ex_branch_taken = 0;
      dec(1, 9, 1, 0, 0, 0, 0, 0); settle();
      chk("br_ex_invalid", 32'(fwd_a_sel), 0);
      chk("br_cnt", 32'(stall_cycles), 0);
      advance();

      // Memory freeze: 3 wait cycles plus release, held branch killed afterwards
      do_reset();
      dec(1, 0, 0, 0, 0, 5, 1, 0); step();
      dec(1, 5, 1, 0, 0, 11, 1, 0); ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1;
         settle();
         chk("frz_ex_stall", 32'(ex_stall), 1);
         chk("frz_no_kill", 32'(ir_kill), 0);
         chk("frz_shadow_hold", 32'(fwd_a_sel), 1);
         advance();
      end
      mem_req = 0; mem_ready = 0; settle();
      chk("rel_ex_stall", 32'(ex_stall), 0);
      chk("rel_ir_kill", 32'(ir_kill), 1);
      chk("rel_cnt", 32'(stall_cycles), 4);
      advance();
      ex_branch_taken = 0;

      // Reset during WAIT
      do_reset();
      mem_req = 1; mem_ready = 0; step(); step();
      quiet(); rst = 1; step(); rst = 0;
      settle();
      chk("rw_ex_stall", 32'(ex_stall), 0);
      chk("rw_pc_stall", 32'(pc_stall), 0);
      chk("rw_cnt", 32'(stall_cycles), 0);
      advance();

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         rst             = ($urandom_range(0, 199) == 0);
         dec_valid       = $urandom_range(0, 3) != 0;
         dec_rs1         = 5'($urandom_range(0, 3));
         dec_rs2         = 5'($urandom_range(0, 3));
         dec_use_rs1     = 1'($urandom_range(0, 1));
         dec_use_rs2     = 1'($urandom_range(0, 1));
         dec_rd          = 5'($urandom_range(0, 3));
         dec_reg_wen     = $urandom_range(0, 3) != 0;
         dec_is_load     = $urandom_range(0, 2) == 0;
         ex_branch_taken = $urandom_range(0, 7) == 0;
         mem_req         = $urandom_range(0, 5) == 0;
         mem_ready       = 1'($urandom_range(0, 1));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
